// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file (x1..x31, x0 hard-wired to zero) with a per-register
// outstanding-write counter used by decode to detect read-after-write hazards.
//
// Decode-side handshake: a source is "requested" when r<s>valid_i is high in
// a cycle. rsreserved_o is the stall indication for that same cycle; decode
// only advances (and only asserts rdreserve_i) in cycles where
// rsreserved_o is low. A reservation is taken at the clock edge where
// rdreserve_i is high and retired at the edge where wb_valid_i names the
// same register. The hazard path never depends on rdreserve_i, so there is
// no combinational loop through decode.
//
// Optional feature (compile-time macro RF_WB_BYPASS_EN):
//   defined   -> a source whose only outstanding write is committing this
//                cycle is forwarded from wb_data_i and does not stall.
//   undefined -> no forwarding; the stall lasts through the writeback cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   r0num_i/r0valid_i   source 0 index and request
//   r1num_i/r1valid_i   source 1 index and request
//   rdnum_i/rdreserve_i destination reservation
//   r0data_o/r1data_o   combinational read data
//   rsreserved_o        a requested source has an outstanding write
//   wb_valid_i/wb_rdnum_i/wb_data_i  writeback commit
//   flush_i             drop all outstanding reservations
//   err_o               sticky: counter overflow or writeback to unreserved reg
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int RSV_W = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      r0num_i,
    input  logic            r0valid_i,
    input  logic [4:0]      r1num_i,
    input  logic            r1valid_i,
    input  logic [4:0]      rdnum_i,
    input  logic            rdreserve_i,
    output logic [XLEN-1:0] r0data_o,
    output logic [XLEN-1:0] r1data_o,
    output logic            rsreserved_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rdnum_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            err_o
);

    localparam logic [RSV_W-1:0] CNT_MAX = '1;
    localparam logic [RSV_W-1:0] CNT_ONE = RSV_W'(1);

    // Entry 0 of both arrays is only ever reset, so x0 reads zero and is
    // never seen as reserved.
    logic [XLEN-1:0]  regs    [32];
    logic [RSV_W-1:0] cnt     [32];
    logic [RSV_W-1:0] cnt_nxt [32];

    // One-hot per-register increment/decrement requests; bit 0 masked so
    // reservations and writebacks to x0 never touch anything.
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;
    logic        err_set;

    assign inc_vec = rdreserve_i ? ((32'd1 << rdnum_i)    & ~32'd1) : 32'd0;
    assign dec_vec = wb_valid_i  ? ((32'd1 << wb_rdnum_i) & ~32'd1) : 32'd0;

    // Next counter values. A simultaneous reserve and retire of the same
    // register cancel out. Saturating at either end holds the counter and
    // flags an error; a flush wins over everything and raises no error.
    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        cnt_nxt[0] = '0;
        for (int i = 1; i < 32; i++) begin
            if (flush_i) begin
                cnt_nxt[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt[i] == '0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err_o <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // Writeback data lands even during a flush: the instruction
            // committing this cycle is older than anything being flushed.
            if (wb_valid_i && wb_rdnum_i != 5'd0) begin
                regs[wb_rdnum_i] <= wb_data_i;
            end
            err_o <= err_o | err_set;
        end
    end

    // Forwarding is allowed only when the committing write is the last one
    // outstanding; with more in flight the register is still not final.
    logic fwd0;
    logic fwd1;

`ifdef RF_WB_BYPASS_EN
    assign fwd0 = r0valid_i && wb_valid_i && (wb_rdnum_i == r0num_i) &&
                  (r0num_i != 5'd0) && (cnt[r0num_i] == CNT_ONE);
    assign fwd1 = r1valid_i && wb_valid_i && (wb_rdnum_i == r1num_i) &&
                  (r1num_i != 5'd0) && (cnt[r1num_i] == CNT_ONE);
`else
    assign fwd0 = 1'b0;
    assign fwd1 = 1'b0;
`endif

    logic hz0;
    logic hz1;

    assign hz0 = r0valid_i && (r0num_i != 5'd0) && (cnt[r0num_i] != '0) && !fwd0;
    assign hz1 = r1valid_i && (r1num_i != 5'd0) && (cnt[r1num_i] != '0) && !fwd1;

    // Outputs are forced quiet while reset is held so decode sees neither
    // stale data nor a spurious stall.
    assign rsreserved_o = !rst && (hz0 || hz1);
    assign r0data_o     = rst ? '0 : (fwd0 ? wb_data_i : regs[r0num_i]);
    assign r1data_o     = rst ? '0 : (fwd1 ? wb_data_i : regs[r1num_i]);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic
// checked against a behavioural model (register values and outstanding-write
// counts held as plain integers). Build with +define+RF_WB_BYPASS_EN to check
// the forwarding variant.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int RSV_W = 2;
    localparam int CMAX  = (1 << RSV_W) - 1;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]      r0num = '0, r1num = '0, rdnum = '0, wb_rdnum = '0;
    logic            r0valid = 1'b0, r1valid = 1'b0, rdreserve = 1'b0;
    logic            wb_valid = 1'b0, flush = 1'b0;
    logic [XLEN-1:0] wb_data = '0;
    logic [XLEN-1:0] r0data, r1data;
    logic            rsreserved, err;

    regfile_scoreboard #(.RSV_W(RSV_W), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0num_i      (r0num),
        .r0valid_i    (r0valid),
        .r1num_i      (r1num),
        .r1valid_i    (r1valid),
        .rdnum_i      (rdnum),
        .rdreserve_i  (rdreserve),
        .r0data_o     (r0data),
        .r1data_o     (r1data),
        .rsreserved_o (rsreserved),
        .wb_valid_i   (wb_valid),
        .wb_rdnum_i   (wb_rdnum),
        .wb_data_i    (wb_data),
        .flush_i      (flush),
        .err_o        (err)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_reg [32];
    int              m_cnt [32];
    logic            m_err;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    // Net change per register = reservations - commits; a result outside
    // 0..CMAX is refused and flagged. Flush zeroes everything.
    task automatic model_step();
        for (int i = 1; i < 32; i++) begin
            int d;
            d = 0;
            if (rdreserve && rdnum == 5'(i)) d = d + 1;
            if (wb_valid && wb_rdnum == 5'(i)) d = d - 1;
            if (flush) m_cnt[i] = 0;
            else if (m_cnt[i] + d > CMAX || m_cnt[i] + d < 0) m_err = 1'b1;
            else m_cnt[i] = m_cnt[i] + d;
        end
        if (wb_valid && wb_rdnum != 5'd0) m_reg[wb_rdnum] = wb_data;
    endtask

    function automatic logic m_fwd(logic [4:0] n, logic v);
        return BYPASS && v && wb_valid && wb_rdnum == n && n != 5'd0 && m_cnt[n] == 1;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(logic [4:0] n, logic v);
        if (rst) return '0;
        if (m_fwd(n, v)) return wb_data;
        if (n == 5'd0) return '0;
        return m_reg[n];
    endfunction

    function automatic logic exp_hz();
        logic a, b;
        if (rst) return 1'b0;
        a = r0valid && r0num != 5'd0 && m_cnt[r0num] != 0 && !m_fwd(r0num, r0valid);
        b = r1valid && r1num != 5'd0 && m_cnt[r1num] != 0 && !m_fwd(r1num, r1valid);
        return a || b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        r0num = '0; r0valid = 1'b0; r1num = '0; r1valid = 1'b0;
        rdnum = '0; rdreserve = 1'b0; wb_valid = 1'b0; wb_rdnum = '0;
        wb_data = '0; flush = 1'b0;
    endtask

    // Inputs change only at the falling edge; the model consumes them at
    // the rising edge, outputs are sampled after the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        r0num = 5'($urandom_range(1, 31)); r0valid = 1'b1;
        r1num = 5'($urandom_range(1, 31)); r1valid = 1'b1;
        wb_valid = 1'b1; wb_rdnum = r0num; wb_data = $urandom;
        rdreserve = 1'b1; rdnum = r1num;
        @(negedge clk);
        #1;
        checks++; if (r0data !== '0) begin errors++; $display("FAIL rst_r0data got %h exp 0", r0data); end
        checks++; if (r1data !== '0) begin errors++; $display("FAIL rst_r1data got %h exp 0", r1data); end
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b exp 0", rsreserved); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        idle();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            r0num = 5'(i); r0valid = 1'b1;
            r1num = 5'(31 - i); r1valid = 1'b1;
            #1;
            checks++; if (r0data !== '0) begin errors++; $display("FAIL t1_r0data x%0d got %h exp 0", i, r0data); end
            checks++; if (r1data !== '0) begin errors++; $display("FAIL t1_r1data x%0d got %h exp 0", 31 - i, r1data); end
            checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t1_hazard x%0d got %b exp 0", i, rsreserved); end
            tick();
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", err); end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        rdnum = 5'd5; rdreserve = 1'b1;
        tick();
        idle();
        r0num = 5'd5; r0valid = 1'b1;
        #1;
        checks++; if (rsreserved !== 1'b1) begin errors++; $display("FAIL t2_reserved got %b exp 1", rsreserved); end
        tick();
        wb_valid = 1'b1; wb_rdnum = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        if (BYPASS) begin
            checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t2_bypass_hz got %b exp 0", rsreserved); end
            checks++; if (r0data !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_bypass_data got %h exp deadbeef", r0data); end
        end else begin
            checks++; if (rsreserved !== 1'b1) begin errors++; $display("FAIL t2_wb_cycle_hz got %b exp 1", rsreserved); end
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t2_after_hz got %b exp 0", rsreserved); end
        checks++; if (r0data !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_after_data got %h exp deadbeef", r0data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t2_err got %b exp 0", err); end
    endtask

    task automatic test_multi_reserve();
        logic [XLEN-1:0] a, b;
        a = $urandom; b = $urandom;
        do_reset();
        rdnum = 5'd7; rdreserve = 1'b1;
        tick();
        tick();
        idle();
        wb_valid = 1'b1; wb_rdnum = 5'd7; wb_data = a;
        tick();
        idle();
        r1num = 5'd7; r1valid = 1'b1;
        #1;
        checks++; if (rsreserved !== 1'b1) begin errors++; $display("FAIL t3_still_reserved got %b exp 1", rsreserved); end
        checks++; if (r1data !== a) begin errors++; $display("FAIL t3_first_data got %h exp %h", r1data, a); end
        wb_valid = 1'b1; wb_rdnum = 5'd7; wb_data = b;
        #1;
        checks++; if (rsreserved !== !BYPASS) begin errors++; $display("FAIL t3_wb2_hz got %b exp %b", rsreserved, !BYPASS); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t3_cleared got %b exp 0", rsreserved); end
        checks++; if (r1data !== b) begin errors++; $display("FAIL t3_last_data got %h exp %h", r1data, b); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t3_err got %b exp 0", err); end
    endtask

    task automatic test_same_cycle();
        logic [XLEN-1:0] c;
        c = $urandom;
        do_reset();
        rdnum = 5'd9; rdreserve = 1'b1;
        tick();
        wb_valid = 1'b1; wb_rdnum = 5'd9; wb_data = c;
        tick();
        idle();
        r1num = 5'd9; r1valid = 1'b1;
        #1;
        checks++; if (rsreserved !== 1'b1) begin errors++; $display("FAIL t4_held got %b exp 1", rsreserved); end
        checks++; if (r1data !== c) begin errors++; $display("FAIL t4_data got %h exp %h", r1data, c); end
        wb_valid = 1'b1; wb_rdnum = 5'd9; wb_data = c;
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t4_retired got %b exp 0", rsreserved); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_err got %b exp 0", err); end
    endtask

    task automatic test_flush();
        do_reset();
        rdnum = 5'd3; rdreserve = 1'b1;
        tick();
        rdnum = 5'd4;
        tick();
        idle();
        flush = 1'b1;
        tick();
        idle();
        r0num = 5'd3; r0valid = 1'b1; r1num = 5'd4; r1valid = 1'b1;
        #1;
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t5_flushed got %b exp 0", rsreserved); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_err_pre got %b exp 0", err); end
        wb_valid = 1'b1; wb_rdnum = 5'd3; wb_data = 32'h12;
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (r0data !== 32'h12) begin errors++; $display("FAIL t5_late_data got %h exp 12", r0data); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5_err_late got %b exp 1", err); end
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t5_hz_late got %b exp 0", rsreserved); end
    endtask

    task automatic test_x0_overflow();
        do_reset();
        wb_valid = 1'b1; wb_rdnum = 5'd0; wb_data = 32'hFFFFFFFF;
        rdreserve = 1'b1; rdnum = 5'd0;
        tick();
        idle();
        r0num = 5'd0; r0valid = 1'b1; r1num = 5'd0; r1valid = 1'b1;
        #1;
        checks++; if (r0data !== '0) begin errors++; $display("FAIL t6_x0_data got %h exp 0", r0data); end
        checks++; if (rsreserved !== 1'b0) begin errors++; $display("FAIL t6_x0_hz got %b exp 0", rsreserved); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t6_x0_err got %b exp 0", err); end
        idle();
        rdnum = 5'd2; rdreserve = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (err !== (k == 4)) begin errors++; $display("FAIL t6_ovf_err after %0d got %b exp %b", k, err, k == 4); end
        end
        idle();
        r0num = 5'd2; r0valid = 1'b1;
        // Counter must have held at 3: three commits needed to clear it.
        for (int k = 1; k <= 3; k++) begin
            wb_valid = 1'b1; wb_rdnum = 5'd2; wb_data = 32'(k);
            tick();
            wb_valid = 1'b0;
            #1;
            checks++;
            if (rsreserved !== (k < 3)) begin errors++; $display("FAIL t6_drain_hz after %0d got %b exp %b", k, rsreserved, k < 3); end
        end
    endtask

    task automatic test_random();
        logic [4:0] pend_q[$];
        logic [XLEN-1:0] e0, e1;
        logic eh;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            r0num = 5'($urandom_range(0, 7)); r0valid = 1'($urandom_range(0, 1));
            r1num = 5'($urandom_range(0, 7)); r1valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                rdreserve = 1'b1;
                rdnum = 5'($urandom_range(0, 7));
                if (rdnum != 5'd0) pend_q.push_back(rdnum);
            end
            if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_valid = 1'b1;
                wb_rdnum = pend_q.pop_front();
                wb_data = $urandom;
            end else if ($urandom_range(0, 39) == 0) begin
                wb_valid = 1'b1;
                wb_rdnum = 5'($urandom_range(0, 7));
                wb_data = $urandom;
            end
            if ($urandom_range(0, 29) == 0) begin
                flush = 1'b1;
                pend_q.delete();
            end
            #1;
            e0 = exp_data(r0num, r0valid);
            e1 = exp_data(r1num, r1valid);
            eh = exp_hz();
            checks++; if (r0data !== e0) begin errors++; $display("FAIL rnd_r0data cyc %0d x%0d got %h exp %h", cyc, r0num, r0data, e0); end
            checks++; if (r1data !== e1) begin errors++; $display("FAIL rnd_r1data cyc %0d x%0d got %h exp %h", cyc, r1num, r1data, e1); end
            checks++; if (rsreserved !== eh) begin errors++; $display("FAIL rnd_hazard cyc %0d got %b exp %b", cyc, rsreserved, eh); end
            tick();
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, err, m_err); end
        end
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_clear();
        test_reset();
        test_raw_hazard();
        test_multi_reserve();
        test_same_cycle();
        test_flush();
        test_x0_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
